// File: rtl/pair_event_collector_if.sv
// Report channel of the pair event collector: snapshot counts plus valid/ready handshake.
// The collector drives the master side; the downstream consumer owns out_ready.
interface pair_event_collector_if #(
    parameter int CNT_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_cnt1;
    logic [CNT_W-1:0] out_cnt2;
    logic             out_sat;

    modport master (
        output out_valid,
        output out_cnt1,
        output out_cnt2,
        output out_sat,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_cnt1,
        input  out_cnt2,
        input  out_sat,
        output out_ready
    );
endinterface

// File: rtl/pair_event_collector.sv
// Counts rising edges on two channels and reports a snapshot at threshold or on flush; 1-cycle latency.
// A pending report is held stable while out_ready is low, and live counting continues meanwhile.
module pair_event_collector #(
    parameter int CNT_W  = 8,
    parameter int THRESH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in1,
    input  logic                   in2,
    input  logic                   flush,
    pair_event_collector_if.master rpt
);
    typedef enum logic {
        COUNT  = 1'b0,
        REPORT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

    state_t           state_q, state_d;
    logic             prev1_q, prev2_q;
    logic [CNT_W-1:0] cnt1_q, cnt2_q, cnt1_d, cnt2_d;
    logic [CNT_W-1:0] ocnt1_q, ocnt2_q, ocnt1_d, ocnt2_d;
    logic             osat_q, osat_d;
    logic             e1, e2, trig;
    logic [CNT_W-1:0] n1, n2;

    assign e1 = in1 & ~prev1_q;
    assign e2 = in2 & ~prev2_q;

    // Saturate instead of wrapping so a flooded channel still reads as "many".
    assign n1 = (e1 && cnt1_q != CNT_MAX) ? cnt1_q + CNT_W'(1) : cnt1_q;
    assign n2 = (e2 && cnt2_q != CNT_MAX) ? cnt2_q + CNT_W'(1) : cnt2_q;

    assign trig = (n1 >= THR) | (n2 >= THR) | flush;

    always_comb begin
        state_d = state_q;
        cnt1_d  = n1;
        cnt2_d  = n2;
        ocnt1_d = ocnt1_q;
        ocnt2_d = ocnt2_q;
        osat_d  = osat_q;
        case (state_q)
            COUNT: begin
                if (trig) begin
                    ocnt1_d = n1;
                    ocnt2_d = n2;
                    osat_d  = (n1 == CNT_MAX) | (n2 == CNT_MAX);
                    cnt1_d  = '0;
                    cnt2_d  = '0;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                // Triggers are dropped here; live counts carry over into the next report.
                if (rpt.out_ready) begin
                    state_d = COUNT;
                end
            end
            default: state_d = COUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COUNT;
            prev1_q <= 1'b0;
            prev2_q <= 1'b0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            ocnt1_q <= '0;
            ocnt2_q <= '0;
            osat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev1_q <= in1;
            prev2_q <= in2;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            ocnt1_q <= ocnt1_d;
            ocnt2_q <= ocnt2_d;
            osat_q  <= osat_d;
        end
    end

    assign rpt.out_valid = (state_q == REPORT);
    assign rpt.out_cnt1  = ocnt1_q;
    assign rpt.out_cnt2  = ocnt2_q;
    assign rpt.out_sat   = osat_q;
endmodule

// File: tb/tb_pair_event_collector.sv
// Bench for pair_event_collector: two instances (8-bit/16 and 4-bit/15) share stimulus and are
// compared every cycle against an integer reference model, plus directed scenario checks.
module tb_pair_event_collector;
    logic clk;
    logic rst;
    logic in1;
    logic in2;
    logic flush;

    pair_event_collector_if #(.CNT_W(8)) ra ();
    pair_event_collector_if #(.CNT_W(4)) rb ();

    pair_event_collector #(.CNT_W(8), .THRESH(16)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .in1   (in1),
        .in2   (in2),
        .flush (flush),
        .rpt   (ra)
    );

    pair_event_collector #(.CNT_W(4), .THRESH(15)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .in1   (in1),
        .in2   (in2),
        .flush (flush),
        .rpt   (rb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: integer edge counts with min() saturation and a pending-report flag.
    int m_prev1[2];
    int m_prev2[2];
    int m_c1[2];
    int m_c2[2];
    int m_o1[2];
    int m_o2[2];
    int m_sat[2];
    int m_pend[2];

    task automatic model_tick(input int k, input bit i1, input bit i2, input bit fl,
                              input bit rd, input bit rs);
        int mx;
        int th;
        int n1;
        int n2;
        mx = (k == 0) ? 255 : 15;
        th = (k == 0) ? 16 : 15;
        if (rs) begin
            m_prev1[k] = 0; m_prev2[k] = 0; m_c1[k] = 0; m_c2[k] = 0;
            m_o1[k] = 0; m_o2[k] = 0; m_sat[k] = 0; m_pend[k] = 0;
            return;
        end
        n1 = m_c1[k] + ((i1 && m_prev1[k] == 0) ? 1 : 0);
        n2 = m_c2[k] + ((i2 && m_prev2[k] == 0) ? 1 : 0);
        if (n1 > mx) n1 = mx;
        if (n2 > mx) n2 = mx;
        if (m_pend[k] == 0) begin
            if (n1 >= th || n2 >= th || fl) begin
                m_o1[k] = n1;
                m_o2[k] = n2;
                m_sat[k] = (n1 == mx || n2 == mx) ? 1 : 0;
                m_c1[k] = 0;
                m_c2[k] = 0;
                m_pend[k] = 1;
            end else begin
                m_c1[k] = n1;
                m_c2[k] = n2;
            end
        end else begin
            m_c1[k] = n1;
            m_c2[k] = n2;
            if (rd) m_pend[k] = 0;
        end
        m_prev1[k] = i1 ? 1 : 0;
        m_prev2[k] = i2 ? 1 : 0;
    endtask

    task automatic check_all();
        chk("a_valid", int'(ra.out_valid), m_pend[0]);
        chk("a_cnt1",  int'(ra.out_cnt1),  m_o1[0]);
        chk("a_cnt2",  int'(ra.out_cnt2),  m_o2[0]);
        chk("a_sat",   int'(ra.out_sat),   m_sat[0]);
        chk("b_valid", int'(rb.out_valid), m_pend[1]);
        chk("b_cnt1",  int'(rb.out_cnt1),  m_o1[1]);
        chk("b_cnt2",  int'(rb.out_cnt2),  m_o2[1]);
        chk("b_sat",   int'(rb.out_sat),   m_sat[1]);
    endtask

    // Inputs are applied 1 time unit after a rising edge and outputs sampled 1 unit after the next.
    task automatic step(input bit i1, input bit i2, input bit fl, input bit rd, input bit rs);
        in1 = i1;
        in2 = i2;
        flush = fl;
        rst = rs;
        ra.out_ready = rd;
        rb.out_ready = rd;
        @(posedge clk);
        model_tick(0, i1, i2, fl, rd, rs);
        model_tick(1, i1, i2, fl, rd, rs);
        #1;
        check_all();
    endtask

    initial begin
        in1 = 1'b0; in2 = 1'b0; flush = 1'b0; rst = 1'b1;
        ra.out_ready = 1'b0;
        rb.out_ready = 1'b0;

        // Reset state
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rst_valid", int'(ra.out_valid), 0);
        chk("rst_cnt1",  int'(ra.out_cnt1),  0);

        // 16 single-cycle pulses on in1 reach the threshold of instance a
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 0, 0);
            if (i < 15) begin
                chk("t1_early_valid", int'(ra.out_valid), 0);
                step(0, 0, 0, 0, 0);
            end
        end
        chk("t1_valid", int'(ra.out_valid), 1);
        chk("t1_cnt1",  int'(ra.out_cnt1),  16);
        chk("t1_cnt2",  int'(ra.out_cnt2),  0);
        chk("t1_sat",   int'(ra.out_sat),   0);
        step(0, 0, 0, 1, 0);
        chk("t1_accept", int'(ra.out_valid), 0);

        // Held-high level is a single edge
        for (int i = 0; i < 40; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 1, 1, 0);
        chk("t2_valid", int'(ra.out_valid), 1);
        chk("t2_cnt1",  int'(ra.out_cnt1),  1);
        chk("t2_cnt2",  int'(ra.out_cnt2),  0);
        step(0, 0, 0, 1, 0);

        // Report held stable under backpressure while in2 keeps counting
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, (i % 2) == 0, 0, 0, 0);
            chk("t3_hold_valid", int'(ra.out_valid), 1);
            chk("t3_hold_cnt2",  int'(ra.out_cnt2),  0);
        end
        step(0, 0, 0, 1, 0);
        chk("t3_accept", int'(ra.out_valid), 0);
        step(0, 0, 1, 0, 0);
        chk("t3_cnt2", int'(ra.out_cnt2), 5);
        step(0, 0, 0, 1, 0);

        // Instance b: simultaneous edges to saturation of a 4-bit counter
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) begin
            step(1, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        chk("t4_valid", int'(rb.out_valid), 1);
        chk("t4_cnt1",  int'(rb.out_cnt1),  15);
        chk("t4_cnt2",  int'(rb.out_cnt2),  15);
        chk("t4_sat",   int'(rb.out_sat),   1);
        step(0, 0, 0, 1, 0);

        // Flush on first cycle out of reset
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        chk("t5_valid", int'(ra.out_valid), 1);
        chk("t5_cnt1",  int'(ra.out_cnt1),  0);
        chk("t5_sat",   int'(ra.out_sat),   0);
        step(0, 0, 0, 1, 0);
        chk("t5_accept", int'(ra.out_valid), 0);

        // Reset while a report is pending drops it and clears live counts
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 1);
        chk("t6_valid", int'(ra.out_valid), 0);
        chk("t6_cnt1",  int'(ra.out_cnt1),  0);
        step(0, 0, 1, 0, 0);
        chk("t6_flush_cnt1", int'(ra.out_cnt1), 0);
        chk("t6_flush_cnt2", int'(ra.out_cnt2), 0);
        step(0, 0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
